// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam int MD_DATA_W = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Operand/control bus from the EX stage into the mul/div unit and its results back.
interface ex_muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              op_valid_i;
    logic [2:0]        op_i;
    logic [DATA_W-1:0] src_a_i;
    logic [DATA_W-1:0] src_b_i;
    logic              flush_i;
    logic              stall_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              busy_o;

    modport master (
        output op_valid_i, op_i, src_a_i, src_b_i, flush_i,
        input  stall_o, hi_o, lo_o, busy_o
    );

    modport slave (
        input  op_valid_i, op_i, src_a_i, src_b_i, flush_i,
        output stall_o, hi_o, lo_o, busy_o
    );
endinterface

// File: rtl/ex_muldiv_unit_core_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring shift-subtract divide.
module muldiv_core_step #(
    parameter int DATA_W = 32
) (
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [DATA_W-1:0] opb_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
        shifted = {hi_i, lo_i[DATA_W-1]};
        diff    = shifted - {1'b0, opb_i};
        if (is_div_i) begin
            // Borrow out of the 33-bit subtract means the partial remainder stays.
            hi_o = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
            lo_o = {lo_i[DATA_W-2:0], ~diff[DATA_W]};
        end else begin
            hi_o = sum[DATA_W:1];
            lo_o = {sum[0], lo_i[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU with HI/LO registers and hazard stall.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int ITER   = MD_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave bus
);
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wh_q, wh_d, wl_q, wl_d, opb_q, opb_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              is_div_q, is_div_d, qneg_q, qneg_d;
    logic              rneg_q, rneg_d, div0_q, div0_d;

    logic                is_md, is_signed, is_div_op, sa, sb, stall;
    logic                fast_mul;
    logic [DATA_W-1:0]   abs_a, abs_b, step_hi, step_lo, quo_f, rem_f;
    logic [2*DATA_W-1:0] prod_f, fast_res;

    muldiv_core_step #(.DATA_W(DATA_W)) u_step (
        .is_div_i (is_div_q),
        .hi_i     (wh_q),
        .lo_i     (wl_q),
        .opb_i    (opb_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        is_md     = bus.op_valid_i && (bus.op_i == MD_MULT || bus.op_i == MD_MULTU ||
                                       bus.op_i == MD_DIV  || bus.op_i == MD_DIVU);
        is_signed = (bus.op_i == MD_MULT) || (bus.op_i == MD_DIV);
        is_div_op = (bus.op_i == MD_DIV) || (bus.op_i == MD_DIVU);
        sa        = is_signed & bus.src_a_i[DATA_W-1];
        sb        = is_signed & bus.src_b_i[DATA_W-1];
        abs_a     = sa ? -bus.src_a_i : bus.src_a_i;
        abs_b     = sb ? -bus.src_b_i : bus.src_b_i;
        prod_f    = qneg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        // A zero divisor leaves the remainder equal to the dividend; only LO needs forcing.
        quo_f     = div0_q ? '1 : (qneg_q ? -step_lo : step_lo);
        rem_f     = rneg_q ? -step_hi : step_hi;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_prod;
    assign fast_mul  = !is_div_op;
    assign fast_prod = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
    assign fast_res  = (sa ^ sb) ? -fast_prod : fast_prod;
`else
    assign fast_mul  = 1'b0;
    assign fast_res  = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wh_d     = wh_q;
        wl_d     = wl_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stall    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (is_md) begin
                    stall = 1'b1;
                    if (!bus.flush_i) begin
                        if (fast_mul) begin
                            hi_d    = fast_res[2*DATA_W-1:DATA_W];
                            lo_d    = fast_res[DATA_W-1:0];
                            state_d = ST_DONE;
                        end else begin
                            wh_d     = '0;
                            wl_d     = abs_a;
                            opb_d    = abs_b;
                            is_div_d = is_div_op;
                            qneg_d   = sa ^ sb;
                            rneg_d   = sa;
                            div0_d   = is_div_op && (bus.src_b_i == '0);
                            cnt_d    = '0;
                            state_d  = ST_BUSY;
                        end
                    end
                end else if (bus.op_valid_i && !bus.flush_i && bus.op_i == MD_MTHI) begin
                    hi_d = bus.src_a_i;
                end else if (bus.op_valid_i && !bus.flush_i && bus.op_i == MD_MTLO) begin
                    lo_d = bus.src_a_i;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    wh_d  = step_hi;
                    wl_d  = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        if (is_div_q) begin
                            hi_d = rem_f;
                            lo_d = quo_f;
                        end else begin
                            hi_d = prod_f[2*DATA_W-1:DATA_W];
                            lo_d = prod_f[DATA_W-1:0];
                        end
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wh_q     <= '0;
            wl_q     <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wh_q     <= wh_d;
            wl_q     <= wl_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.stall_o = stall;
    assign bus.busy_o  = (state_q == ST_BUSY);
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: fixed vector table, corner sequences, random ops vs arithmetic model.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif
    localparam int DIV_STALL = 33;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    vec_t vecs [10];

    ex_muldiv_unit_if #(.DATA_W(32)) bus ();
    ex_muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_in();
        bus.op_valid_i = 1'b0;
        bus.op_i       = MD_NONE;
        bus.src_a_i    = '0;
        bus.src_b_i    = '0;
        bus.flush_i    = 1'b0;
    endtask

    // Issues one op, holds it while stalled, and samples HI/LO in the first non-stall cycle.
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          output int st, output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        bus.op_valid_i = 1'b1;
        bus.op_i       = op;
        bus.src_a_i    = a;
        bus.src_b_i    = b;
        st = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!bus.stall_o) break;
            st++;
            @(negedge clk);
        end
        hi = bus.hi_o;
        lo = bus.lo_o;
        bus.op_valid_i = 1'b0;
        bus.op_i       = MD_NONE;
    endtask

    function automatic logic [63:0] ref_md(input md_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            MD_MULT:  p = 64'(sa * sb);
            MD_MULTU: p = {32'h0, a} * {32'h0, b};
            MD_DIV: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            MD_DIVU: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: p = '0;
        endcase
        return p;
    endfunction

    initial begin
        int          st;
        int          exp_st;
        logic [31:0] hi, lo, a, b;
        logic [63:0] exp;
        md_op_e      op;

        vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MD_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
        vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[6] = '{MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{MD_MULT,  32'd5,         32'd6,         32'd0,         32'd30};
        vecs[8] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF};
        vecs[9] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};

        idle_in();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hi", bus.hi_o, 0);
        chk("rst_lo", bus.lo_o, 0);
        chk("rst_stall", bus.stall_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, st, hi, lo);
            exp_st = (vecs[i].op == MD_DIV || vecs[i].op == MD_DIVU) ? DIV_STALL : MUL_STALL;
            chk($sformatf("vec%0d_stall", i), st, exp_st);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // MTHI then MTLO back to back: no stall, each visible the following cycle.
        @(negedge clk);
        bus.op_valid_i = 1'b1;
        bus.op_i       = MD_MTHI;
        bus.src_a_i    = 32'h1234_5678;
        #1 chk("mthi_stall", bus.stall_o, 0);
        @(negedge clk);
        chk("mthi_hi", bus.hi_o, 32'h1234_5678);
        bus.op_i    = MD_MTLO;
        bus.src_a_i = 32'hCAFE_0000;
        #1 chk("mtlo_stall", bus.stall_o, 0);
        @(negedge clk);
        chk("mtlo_lo", bus.lo_o, 32'hCAFE_0000);
        chk("mtlo_hi_kept", bus.hi_o, 32'h1234_5678);

        // Reserved opcode with valid set does nothing.
        bus.op_i    = 3'b111;
        bus.src_a_i = 32'hDEAD_BEEF;
        #1 chk("op7_stall", bus.stall_o, 0);
        @(negedge clk);
        chk("op7_busy", bus.busy_o, 0);
        chk("op7_hi", bus.hi_o, 32'h1234_5678);
        idle_in();

        // DIV flushed at BUSY cycle 10.
        @(negedge clk);
        bus.op_valid_i = 1'b1;
        bus.op_i       = MD_DIV;
        bus.src_a_i    = 32'd100;
        bus.src_b_i    = 32'd7;
        repeat (11) @(negedge clk);
        chk("fl_busy_before", bus.busy_o, 1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        idle_in();
        #1;
        chk("fl_stall", bus.stall_o, 0);
        chk("fl_busy", bus.busy_o, 0);
        chk("fl_hi", bus.hi_o, 32'h1234_5678);
        chk("fl_lo", bus.lo_o, 32'hCAFE_0000);

        // Flush in the accept cycle: nothing starts.
        @(negedge clk);
        bus.op_valid_i = 1'b1;
        bus.op_i       = MD_DIVU;
        bus.src_a_i    = 32'd9;
        bus.src_b_i    = 32'd2;
        bus.flush_i    = 1'b1;
        #1 chk("fla_stall_accept", bus.stall_o, 1);
        @(negedge clk);
        idle_in();
        #1;
        chk("fla_busy", bus.busy_o, 0);
        chk("fla_lo", bus.lo_o, 32'hCAFE_0000);

        run_op(MD_MULT, 32'd5, 32'd6, st, hi, lo);
        chk("post_fl_hi", hi, 0);
        chk("post_fl_lo", lo, 30);

        // Flush during DONE must not undo the write.
        run_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, st, hi, lo);
        chk("done_hi", hi, 32'hFFFF_FFFF);
        chk("done_lo", lo, 32'hFFFF_FFEB);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        chk("done_fl_hi", bus.hi_o, 32'hFFFF_FFFF);
        chk("done_fl_lo", bus.lo_o, 32'hFFFF_FFEB);

        for (int n = 0; n < 40; n++) begin
            op = md_op_e'($urandom_range(1, 4));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: a = 32'h8000_0000;
                3: b = '1;
                default: ;
            endcase
            run_op(op, a, b, st, hi, lo);
            exp    = ref_md(op, a, b);
            exp_st = (op == MD_DIV || op == MD_DIVU) ? DIV_STALL : MUL_STALL;
            chk($sformatf("rnd%0d_stall op%0d", n, op), st, exp_st);
            chk($sformatf("rnd%0d_hi op%0d a=%h b=%h", n, op, a, b), hi, exp[63:32]);
            chk($sformatf("rnd%0d_lo op%0d a=%h b=%h", n, op, a, b), lo, exp[31:0]);
        end

        // Reset in the middle of a multi-cycle op.
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, hi, lo);
        @(negedge clk);
        bus.op_valid_i = 1'b1;
        bus.op_i       = MD_DIVU;
        bus.src_a_i    = 32'd1000;
        bus.src_b_i    = 32'd3;
        repeat (6) @(negedge clk);
        chk("mid_busy", bus.busy_o, 1);
        rst = 1'b1;
        idle_in();
        @(negedge clk);
        chk("mid_rst_hi", bus.hi_o, 0);
        chk("mid_rst_lo", bus.lo_o, 0);
        chk("mid_rst_stall", bus.stall_o, 0);
        chk("mid_rst_busy", bus.busy_o, 0);
        rst = 1'b0;

        run_op(MD_DIVU, 32'd1000, 32'd3, st, hi, lo);
        chk("after_rst_hi", hi, 1);
        chk("after_rst_lo", lo, 333);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
EX-stage multi-cycle multiply/divide unit with the architectural HI/LO registers. It sits directly downstream of the EX operand-select muxes. It consumes the selected/forwarded A and B operands that also feed the ALU. It executes MULT/MULTU/DIV/DIVU iteratively, services MTHI/MTLO, and drives a stall request to the hazard unit while an operation is in flight.

Parameters:
- DATA_W, 32, operand and HI/LO width
- ITER, 32, iterations per multi-cycle op (must equal DATA_W)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- op_valid_i  in  1  EX holds a mul/div-class instruction; held stable while stall_o is high
- op_i  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
- src_a_i  in  32  rs operand (ALU source-A path output)
- src_b_i  in  32  rt operand (forwarded B)
- flush_i  in  1  EX flush; aborts the in-flight op
- stall_o  out  1  freeze IF/ID/EX
- hi_o  out  32  HI register (MFHI source)
- lo_o  out  32  LO register (MFLO source)
- busy_o  out  1  state is BUSY

Behaviour:
- Reset: state IDLE, hi_o=0, lo_o=0, busy_o=0, stall_o=0, counter=0, all working regs=0. Reset overrides flush_i and any pending start.
- FSM states:
  - IDLE: accepts op when op_valid_i and op_i in {MULT..DIVU}. stall_o=1 combinationally in the accept cycle. Latch |a|, |b| and the result sign for signed ops (raw values for unsigned ops). Go to BUSY with counter=0.
  - BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle. counter increments. stall_o=1, busy_o=1. On counter==ITER-1: apply sign correction, write HI/LO at that edge, go to DONE.
  - DONE: stall_o=0 so the instruction retires from EX. No accept in this state. Go to IDLE.
- Total stall for mul/div is 1+ITER = 33 cycles. HI/LO are valid from the first DONE cycle.
- MTHI/MTLO: accepted in IDLE only, with no stall. hi_o (resp. lo_o) <= src_a_i at the clock edge. They are visible to an MFHI/MFLO in EX on the next cycle.
- Results:
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (b==0): HI = dividend, LO = 32'hFFFF_FFFF. Full latency still applies.
- DIV with 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
- flush_i in BUSY or in the accept cycle: return to IDLE next edge. HI/LO are unchanged and stall_o drops the next cycle. flush_i in DONE has no effect, because the write has already occurred.
- op_valid_i with op_i NONE or 111 is ignored.
- Back-to-back mul/div: the second op is accepted in the IDLE cycle after DONE.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational 32x32 multiplier. IDLE goes to DONE directly, HI/LO are written at the accept edge, and stall_o is high for 1 cycle. DIV/DIVU are unchanged.
- Undefined: multiply is iterative as specified above.

Decomposition:
- Shared package: op encodings (MD_NONE..MD_MTLO), FSM state encodings (ST_IDLE, ST_BUSY, ST_DONE), DATA_W default.
- One natural sub-module: muldiv_core_step, holding the combinational single-iteration datapath (add-shift / subtract-shift, selected by is_div). The top level keeps the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULT a=32'hFFFF_FFFE (-2), b=3 -> stall_o high 33 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- DIV a=-7 (32'hFFFF_FFF9), b=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). DIVU a=7, b=0 -> HI=7, LO=32'hFFFF_FFFF.
- MTHI a=32'h1234_5678, then MTLO a=32'hCAFE_0000 on consecutive cycles -> stall_o never high; both registers updated one cycle after each.
- DIV started, flush_i pulsed at BUSY cycle 10 -> IDLE next cycle, stall_o low, HI/LO keep their prior values. A following MULT 5*6 gives LO=30, HI=0.
- rst asserted mid-BUSY -> next cycle hi_o=0, lo_o=0, stall_o=0, busy_o=0.
